// File: rtl/fp_div_if.sv
// Handshake bundle for fp_div: operand channel (a/b) and result channel (op + flags).
interface fp_div_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] op;
    logic        ovf;
    logic        unf;
    logic        dz;

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, op, ovf, unf, dz
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, op, ovf, unf, dz
    );
endinterface

// File: rtl/fp_div.sv
// Sequential FP32 divider, restoring division one quotient bit per cycle.
// Define FP_DIV_ROUND_EN for round-to-nearest-even; default truncates.
module fp_div (
    input  logic     clk,
    input  logic     rst,
    fp_div_if.slave  io
);
    typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_sign;
    logic [23:0]         r_mb;
    logic [24:0]         r_rem;
    logic [24:0]         r_q;
    logic signed [9:0]   r_exp;
    logic [4:0]          r_cnt;
    logic [31:0]         r_op;
    logic                r_ovf;
    logic                r_unf;
    logic                r_dz;

    logic [7:0]          w_a_exp;
    logic [7:0]          w_b_exp;
    logic                w_sign_in;
    logic signed [9:0]   w_exp_in;
    logic                w_ge;
    logic [24:0]         w_rem_sub;
    logic [22:0]         w_frac;
    logic signed [9:0]   w_exp_n;
    logic [22:0]         w_frac_r;
    logic signed [9:0]   w_exp_r;
    logic [31:0]         w_res_op;
    logic                w_res_ovf;
    logic                w_res_unf;

    assign w_a_exp   = io.a[30:23];
    assign w_b_exp   = io.b[30:23];
    assign w_sign_in = io.a[31] ^ io.b[31];
    assign w_exp_in  = $signed({2'b00, w_a_exp}) - $signed({2'b00, w_b_exp}) + 10'sd127;

    assign io.in_ready  = (r_state == S_IDLE);
    assign io.out_valid = (r_state == S_DONE);
    assign io.op        = r_op;
    assign io.ovf       = r_ovf;
    assign io.unf       = r_unf;
    assign io.dz        = r_dz;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (io.in_valid)
                    w_state_nxt = (w_a_exp == 8'd0 || w_b_exp == 8'd0) ? S_DONE : S_DIVIDE;
            end
            S_DIVIDE: begin
                if (r_cnt == 5'd25) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (io.out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_ge      = (r_rem >= {1'b0, r_mb});
    assign w_rem_sub = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;

    // Result is formed from the final step's combinational bit, so r_q holds Q[25:1] here.
    always_comb begin
        if (r_q[24]) begin
            w_frac  = r_q[23:1];
            w_exp_n = r_exp;
        end else begin
            w_frac  = r_q[22:0];
            w_exp_n = r_exp - 10'sd1;
        end
    end

`ifdef FP_DIV_ROUND_EN
    logic w_guard;
    logic w_sticky;
    assign w_guard  = r_q[24] ? r_q[0] : w_ge;
    assign w_sticky = (r_q[24] & w_ge) | (|w_rem_sub);

    always_comb begin
        w_frac_r = w_frac;
        w_exp_r  = w_exp_n;
        if (w_guard && (w_sticky || w_frac[0])) begin
            if (&w_frac) begin
                w_frac_r = '0;
                w_exp_r  = w_exp_n + 10'sd1;
            end else begin
                w_frac_r = w_frac + 23'd1;
            end
        end
    end
`else
    assign w_frac_r = w_frac;
    assign w_exp_r  = w_exp_n;
`endif

    always_comb begin
        w_res_op  = {r_sign, w_exp_r[7:0], w_frac_r};
        w_res_ovf = 1'b0;
        w_res_unf = 1'b0;
        if (w_exp_r >= 10'sd255) begin
            w_res_op  = {r_sign, 8'hFF, 23'd0};
            w_res_ovf = 1'b1;
        end else if (w_exp_r <= 10'sd0) begin
            w_res_op  = {r_sign, 31'd0};
            w_res_unf = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign <= 1'b0;
            r_mb   <= '0;
            r_rem  <= '0;
            r_q    <= '0;
            r_exp  <= '0;
            r_cnt  <= '0;
            r_op   <= '0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
            r_dz   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io.in_valid) begin
                        r_sign <= w_sign_in;
                        r_mb   <= {1'b1, io.b[22:0]};
                        r_rem  <= {2'b01, io.a[22:0]};
                        r_q    <= '0;
                        r_exp  <= w_exp_in;
                        r_cnt  <= '0;
                        r_ovf  <= 1'b0;
                        r_unf  <= 1'b0;
                        r_dz   <= 1'b0;
                        if (w_a_exp == 8'd0) begin
                            r_op <= {w_sign_in, 31'd0};
                        end else if (w_b_exp == 8'd0) begin
                            r_op <= {w_sign_in, 8'hFF, 23'd0};
                            r_dz <= 1'b1;
                        end
                    end
                end
                S_DIVIDE: begin
                    r_rem <= w_rem_sub << 1;
                    r_q   <= {r_q[23:0], w_ge};
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd25) begin
                        r_cnt <= '0;
                        r_op  <= w_res_op;
                        r_ovf <= w_res_ovf;
                        r_unf <= w_res_unf;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_div.sv
// Directed bench for fp_div: integer-arithmetic reference model, scoreboard checked every cycle out_valid is high.
module tb_fp_div;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_div_if io();
    fp_div dut (.clk(clk), .rst(rst), .io(io));

    typedef struct packed {
        logic [31:0] op;
        logic        ovf;
        logic        unf;
        logic        dz;
    } res_t;

    int   n_vec = 0;
    int   n_err = 0;
    res_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: exact quotient of the 24-bit significands via 64-bit integer division.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
        res_t        r;
        longint      ma, mb, num, q;
        int          e;
        logic [22:0] frac;
        logic        s;
        r = '0;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0) begin
            r.op = {s, 31'd0};
        end else if (b[30:23] == 8'd0) begin
            r.op = {s, 8'hFF, 23'd0};
            r.dz = 1'b1;
        end else begin
            ma   = longint'({1'b1, a[22:0]});
            mb   = longint'({1'b1, b[22:0]});
            num  = ma * 64'sd33554432;
            q    = num / mb;
            e    = int'(a[30:23]) - int'(b[30:23]) + 127;
            if (q >= 64'sd33554432) frac = 23'((q / 4) % 8388608);
            else begin
                e--;
                frac = 23'((q / 2) % 8388608);
            end
`ifdef FP_DIV_ROUND_EN
            begin : rnd
                logic g, st;
                longint rm;
                rm = num % mb;
                g  = (q >= 64'sd33554432) ? (((q / 2) % 2) != 0) : ((q % 2) != 0);
                st = (q >= 64'sd33554432) ? (((q % 2) != 0) || (rm != 0)) : (rm != 0);
                if (g && (st || frac[0])) begin
                    if (frac == 23'h7FFFFF) begin
                        frac = '0;
                        e++;
                    end else begin
                        frac = frac + 23'd1;
                    end
                end
            end
`endif
            if (e >= 255) begin
                r.op  = {s, 8'hFF, 23'd0};
                r.ovf = 1'b1;
            end else if (e <= 0) begin
                r.op  = {s, 31'd0};
                r.unf = 1'b1;
            end else begin
                r.op = {s, 8'(e), frac};
            end
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && io.out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected out_valid", 64'(io.out_valid), 64'd0);
            end else begin
                chk("result", 64'({io.op, io.ovf, io.unf, io.dz}), 64'(exp_q[0]));
                chk("in_ready low while busy", 64'(io.in_ready), 64'd0);
                if (io.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold);
        int lat, exp_lat;
        exp_lat = (a[30:23] == 8'd0 || b[30:23] == 8'd0) ? 1 : 27;
        exp_q.push_back(model(a, b));
        chk("in_ready before accept", 64'(io.in_ready), 64'd1);
        io.in_valid = 1'b1;
        io.a = a;
        io.b = b;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        io.a = $urandom;
        io.b = $urandom;
        lat = 1;
        while (!io.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        repeat (hold) begin
            @(posedge clk); #1;
        end
        io.out_ready = 1'b1;
        @(posedge clk); #1;
        io.out_ready = 1'b0;
        chk("idle after transfer", 64'({io.out_valid, io.in_ready}), 64'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        res_t m;
        io.in_valid  = 1'b0;
        io.out_ready = 1'b0;
        io.a = '0;
        io.b = '0;

        // Pin the model against hand-computed results.
        m = model(32'h40C00000, 32'h40000000); chk("model 6/2", 64'(m), 64'({32'h40400000, 3'b000}));
        m = model(32'hC0C00000, 32'h40000000); chk("model -6/2", 64'(m), 64'({32'hC0400000, 3'b000}));
`ifdef FP_DIV_ROUND_EN
        m = model(32'h3F800000, 32'h40400000); chk("model 1/3", 64'(m), 64'({32'h3EAAAAAB, 3'b000}));
`else
        m = model(32'h3F800000, 32'h40400000); chk("model 1/3", 64'(m), 64'({32'h3EAAAAAA, 3'b000}));
`endif
        m = model(32'h3F800000, 32'h00000000); chk("model x/0", 64'(m), 64'({32'h7F800000, 3'b001}));
        m = model(32'h80000000, 32'h40000000); chk("model -0/2", 64'(m), 64'({32'h80000000, 3'b000}));
        m = model(32'h7F000000, 32'h3F000000); chk("model ovf", 64'(m), 64'({32'h7F800000, 3'b100}));
        m = model(32'h00800000, 32'h40000000); chk("model unf", 64'(m), 64'({32'h00000000, 3'b010}));

        repeat (3) @(posedge clk);
        #1;
        chk("reset state", 64'({io.in_ready, io.out_valid, io.op, io.ovf, io.unf, io.dz}),
            64'({1'b1, 1'b0, 32'd0, 3'b000}));
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(32'h40C00000, 32'h40000000, 0);
        run_op(32'hC0C00000, 32'h40000000, 0);
        run_op(32'h3F800000, 32'h40400000, 2);
        run_op(32'h3F800000, 32'h00000000, 0);
        run_op(32'h80000000, 32'h40000000, 1);
        run_op(32'h00000000, 32'h00000000, 0);
        run_op(32'h7F000000, 32'h3F000000, 0);
        run_op(32'h00800000, 32'h40000000, 0);
        run_op(32'h7F800000, 32'h3F800000, 0);
        run_op(32'h3F800000, 32'h3F800000, 0);
        run_op(32'h40490FDB, 32'h402DF854, 0);
        run_op(32'hC2F60000, 32'hBF400000, 0);
        run_op(32'h3F7FFFFF, 32'h3F800001, 0);
        // Backpressure: stability is checked by the scoreboard on every held cycle.
        run_op(32'h40C00000, 32'h40000000, 10);
        run_op(32'h41200000, 32'h40E00000, 0);

        // Reset in the middle of DIVIDE (counter at 12).
        io.in_valid = 1'b1;
        io.a = 32'h40C00000;
        io.b = 32'h40000000;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid-op reset", 64'({io.in_ready, io.out_valid, io.op, io.ovf, io.unf, io.dz}),
            64'({1'b1, 1'b0, 32'd0, 3'b000}));
        repeat (30) @(posedge clk);
        #1;
        run_op(32'h40C00000, 32'h40000000, 0);

        chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fp_div.md
# fp_div

Sequential IEEE-754 single-precision divider: the counterpart to the team's combinational FP32 multiplier, computing `op = a / b`. It uses restoring long division on the 24-bit significands, one quotient bit per cycle, behind valid/ready handshakes on both input and output. It sits in the FPU datapath next to the multiplier and shares its number model: normal numbers only, exponent-0 inputs treated as zero, no NaN handling.

## Interface
Parameters: none.

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands a/b valid
- in_ready  output  1  block can accept operands (IDLE only)
- a  input  32  dividend {sign, exp[7:0], frac[22:0]}
- b  input  32  divisor, same format
- out_valid  output  1  result valid; held until accepted
- out_ready  input  1  consumer accepts result
- op  output  32  quotient
- ovf  output  1  exponent overflow; op = signed infinity
- unf  output  1  exponent underflow; op = signed zero
- dz  output  1  divide by zero (b exponent == 0, a nonzero)

## Operation
- FSM states: IDLE, DIVIDE, DONE.
- **IDLE**
  - in_ready = 1.
  - On in_valid: latch sign = a[31]^b[31], ma = {1,a[22:0]}, mb = {1,b[22:0]}.
  - e = a_exp − b_exp + 127, computed as 10-bit signed.
- **Special cases** (IDLE → DONE directly, no DIVIDE):
  - b_exp == 0 and a_exp != 0: op = {sign, 8'hFF, 0}, dz = 1.
  - a_exp == 0 (including 0/0): op = {sign, 31'b0}, all flags 0.
- **DIVIDE** (26 cycles, 5-bit counter 0..25)
  - Partial remainder starts at ma.
  - Each cycle: if rem ≥ mb, then q bit = 1 and rem −= mb; else q bit = 0. Then rem <<= 1.
  - Result Q = floor(ma·2^25 / mb), 26 bits.
  - After count 25 → DONE.
- **Normalize**
  - If Q[25]: frac = Q[24:2], guard = Q[1], sticky = Q[0] | (rem != 0).
  - Else: frac = Q[23:1], guard = Q[0], sticky = (rem != 0), and e −= 1.
- **Range check**, after rounding (see Configuration):
  - e ≥ 255: op = {sign, 8'hFF, 0}, ovf = 1.
  - e ≤ 0: op = {sign, 31'b0}, unf = 1.
  - Otherwise: op = {sign, e[7:0], frac}.
- **DONE**
  - out_valid = 1; op and flags stable.
  - On out_ready → IDLE.
- Exponent-255 inputs are ordinary operands (no Inf/NaN decode).

## Timing
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, op = 0, ovf = unf = dz = 0, counter = 0.
- Handshake rules:
  - Input accepted in cycle T when in_valid && in_ready.
  - Output transfers when out_valid && out_ready.
- Latency:
  - Normal path: out_valid rises at T+27 (26 DIVIDE cycles plus DONE entry).
  - Special cases: out_valid rises at T+1.
- Output stability:
  - op and flags are registered, stable for the whole time out_valid is high, and unaffected by a/b changes.
  - Flags clear when the next operation is accepted.
- Throughput and ordering:
  - One operation in flight; in_ready = 0 in DIVIDE and DONE.
  - Back-to-back: result accepted at cycle D, IDLE at D+1, next accept possible at D+1.
  - No bypass from DONE to accept in the same cycle.
- rst asserted in any state: next cycle equals the reset state; the in-flight operation is discarded and no out_valid is emitted for it.
- out_ready held low: stay in DONE indefinitely with op unchanged.

## Configuration
- `FP_DIV_ROUND_EN` defined:
  - Round to nearest even: increment frac when guard && (sticky || frac[0]).
  - If the increment carries out of frac, frac = 0 and e += 1; the range check is applied after this.
  - Latency unchanged.
- Undefined:
  - Truncate; guard and sticky are ignored.
  - Matches the multiplier's truncating behaviour.

## Test plan
- Basic divide: 0x40C00000 / 0x40000000 (6.0/2.0) → op = 0x40400000 at T+27, flags 0. Sign variant: 0xC0C00000 / 0x40000000 → 0xC0400000.
- Rounding: 0x3F800000 / 0x40400000 (1/3) → 0x3EAAAAAA without FP_DIV_ROUND_EN; 0x3EAAAAAB with it.
- Special cases:
  - 0x3F800000 / 0x00000000 → 0x7F800000, dz = 1, out_valid at T+1.
  - 0x80000000 / 0x40000000 → 0x80000000, out_valid at T+1.
- Range limits:
  - 0x7F000000 / 0x3F000000 → 0x7F800000, ovf = 1.
  - 0x00800000 / 0x40000000 → 0x00000000, unf = 1.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid → op stable and in_ready = 0 throughout. Release → IDLE next cycle; a second operand pair is accepted that cycle and produces the correct result.
- Reset mid-operation: assert rst at count 12 of DIVIDE → next cycle in_ready = 1, out_valid = 0, op = 0, all flags 0. A new 6.0/2.0 then completes normally.
